// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-port arbiter in front of a single-ported data memory.
//   Port 0 (pipeline MEM stage) normally has priority. Port 1 (loader/debug)
//   is forced through after it has been denied STARVE_LIMIT cycles in a row.
//   Each accepted request moves through two stages. Stage A registers the
//   request. In stage B the memory is driven and the read data is captured.
//   The response strobe appears two cycles after acceptance.
//
// Parameters
//   STARVE_LIMIT  denied cycles of a pending port-1 request before it wins
//   MEM_BYTES     size of the attached memory in bytes
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   p0_valid/ready/we/addr/wdata   port 0 request handshake and payload
//   p1_valid/ready/we/addr/wdata   port 1 request handshake and payload
//   p0_resp_valid, p1_resp_valid   one-cycle response strobe per port
//   resp_rdata, resp_err           shared response data and error flag
//   mem_ce/we/addr/wdata           memory control and write data
//   mem_rdata                      combinational memory read data
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned MEM_BYTES    = 1024
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        p0_valid,
    output logic        p0_ready,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,

    input  logic        p1_valid,
    output logic        p1_ready,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,

    output logic        p0_resp_valid,
    output logic        p1_resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,

    output logic        mem_ce,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int          DATA_W    = 32;
    localparam int          CNT_MIN_W = $clog2(STARVE_LIMIT + 1);
    localparam int          CNT_W     = (CNT_MIN_W > 3) ? CNT_MIN_W : 3;
    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

    // The counter holds at all-ones so a long denial can never wrap back
    // below the limit.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // A request is rejected if it is misaligned or would run past the
    // last full word of the memory.
    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a > LAST_WORD);
    endfunction

    logic [CNT_W-1:0]  starve_cnt;
    logic              starve;
    logic              p1_win;
    logic              acc;

    logic              vld_p1;
    logic              we_p1;
    logic              port_p1;
    logic              err_p1;
    logic [31:0]       addr_p1;
    logic [DATA_W-1:0] wdata_p1;

    logic              vld_p2;
    logic              port_p2;
    logic              err_p2;
    logic [DATA_W-1:0] rdata_p2;

    // Request arbitration (combinational). Port 1 wins when it is starving
    // or when port 0 is idle.
    assign starve = (starve_cnt >= CNT_W'(STARVE_LIMIT));

    always_comb begin
        p1_win   = p1_valid && (starve || !p0_valid);
        p0_ready = !rst && p0_valid && !p1_win;
        p1_ready = !rst && p1_win;
    end

    assign acc = (p0_valid && p0_ready) || (p1_valid && p1_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (p1_valid && !p1_ready) begin
            starve_cnt <= sat_inc(starve_cnt);
        end else begin
            starve_cnt <= '0;
        end
    end

    // Stage A: register the accepted request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= acc;
        end
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            port_p1  <= p1_ready;
            we_p1    <= p1_ready ? p1_we    : p0_we;
            addr_p1  <= p1_ready ? p1_addr  : p0_addr;
            wdata_p1 <= p1_ready ? p1_wdata : p0_wdata;
            err_p1   <= addr_err(p1_ready ? p1_addr : p0_addr);
        end
    end

    // Stage B: drive the memory. Faulting requests never reach it. An
    // asynchronous reset clears vld_p1, which cancels a pending write
    // right away.
    always_comb begin
        mem_ce    = vld_p1 && !err_p1;
        mem_we    = mem_ce && we_p1;
        mem_addr  = mem_ce ? addr_p1  : 32'd0;
        mem_wdata = mem_ce ? wdata_p1 : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2   <= 1'b0;
            port_p2  <= 1'b0;
            err_p2   <= 1'b0;
            rdata_p2 <= '0;
        end else begin
            vld_p2   <= vld_p1;
            port_p2  <= vld_p1 && port_p1;
            err_p2   <= vld_p1 && err_p1;
            rdata_p2 <= (mem_ce && !we_p1) ? mem_rdata : '0;
        end
    end

    // Response: strobe the originating port for one cycle
    assign p0_resp_valid = vld_p2 && !port_p2;
    assign p1_resp_valid = vld_p2 && port_p2;
    assign resp_err      = err_p2;
    assign resp_rdata    = rdata_p2;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: cycles a pending port-1 request may be denied before port 1 is forced to win.
REQ-002 Parameter MEM_BYTES, default 1024: size of the attached data memory in bytes.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 p0_valid  input  1  port 0 (pipeline MEM stage) request valid.
REQ-006 p0_ready  output  1  port 0 request accepted this cycle.
REQ-007 p0_we  input  1  port 0 write (1) or read (0).
REQ-008 p0_addr  input  32  port 0 byte address.
REQ-009 p0_wdata  input  32  port 0 write data.
REQ-010 p1_valid, p1_ready, p1_we, p1_addr, p1_wdata: same directions, widths and meanings for port 1 (loader/debug).
REQ-011 p0_resp_valid, p1_resp_valid  output  1  one-cycle response strobe per port.
REQ-012 resp_rdata  output  32  read data of the current response (shared by both ports).
REQ-013 resp_err  output  1  current response is an error; no memory access took place.
REQ-014 mem_ce, mem_we  output  1  memory chip enable and write enable.
REQ-015 mem_addr, mem_wdata  output  32  memory byte address and write data.
REQ-016 mem_rdata  input  32  combinational read data from the memory.

Function
REQ-017 Arbitration is combinational each cycle: port 0 wins when p0_valid=1, unless the starvation flag is set and p1_valid=1, in which case port 1 wins.
REQ-018 px_ready=1 only for the winning port, and only when px_valid=1; the losing port's ready=0; a request is accepted on a cycle with valid=1 and ready=1.
REQ-019 Throughput: one accepted request per cycle; there is no stall source other than losing arbitration.
REQ-020 Stage A: on acceptance, we, addr, wdata, port id and an error flag are registered, and stage-A valid is set; otherwise stage-A valid clears.
REQ-021 Error flag = addr[1:0]!=0 or addr>MEM_BYTES-4 (unsigned 32-bit compare).
REQ-022 Stage B (cycle after acceptance): mem_ce=1 iff stage-A valid and error flag=0.
REQ-023 In stage B, mem_we, mem_addr and mem_wdata are driven from the stage-A registers.
REQ-024 When mem_ce=0: mem_we=0, mem_addr=0, mem_wdata=0.
REQ-025 At the end of stage B, for a read, mem_rdata is registered into resp_rdata; for a write or an error, resp_rdata=0.
REQ-026 Response: px_resp_valid=1 for exactly one cycle, two cycles after acceptance, for the port id carried; resp_err is valid in the same cycle.
REQ-027 Responses cannot be back-pressured; responses for each port return in acceptance order.
REQ-028 Starvation counter, 3+ bits saturating: increments on each cycle with p1_valid=1 and p1_ready=0; clears when port 1 is accepted or p1_valid=0.
REQ-029 Starvation flag = counter>=STARVE_LIMIT.
REQ-030 A write followed by a read to the same address on the next cycle returns the new data, because the write commits at the end of its stage B, before the read's stage B.
REQ-031 Simultaneous p0_valid and p1_valid with flag clear: port 0 accepted and port 1 counter increments; with flag set: port 1 accepted, port 0 waits.

Reset
REQ-032 While rst=1, asynchronously: stage-A valid=0, response valid=0, resp_rdata=0, resp_err=0, counter=0, mem_ce=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-033 While rst=1, p0_ready=0 and p1_ready=0.
REQ-034 Reset mid-operation drops all in-flight transactions with no response; a pending write in stage B is not performed once rst=1.
REQ-035 First acceptance is possible on the first posedge clk after rst deasserts.

Verification
REQ-036 p0 read addr 0x10 (mem holds 0xDEADBEEF) -> p0_ready=1 at T, mem_ce=1 and mem_addr=0x10 at T+1, p0_resp_valid=1 with resp_rdata=0xDEADBEEF and resp_err=0 at T+2.
REQ-037 p0 write 0x12345678 to 0x20 at T, p0 read 0x20 at T+1 -> read response at T+3 returns 0x12345678.
REQ-038 p0_valid and p1_valid held high continuously, STARVE_LIMIT=4 -> port 0 accepted for 4 cycles, port 1 accepted on the 5th, then the pattern repeats.
REQ-039 p1 read 0x22 and p1 read 0x3FE -> mem_ce stays 0 for both, p1_resp_valid=1 with resp_err=1 and resp_rdata=0 two cycles after each acceptance.
REQ-040 p0 write accepted at T, rst pulsed during T+1 before the edge -> memory at that address unchanged, no p0_resp_valid, all outputs 0 during reset.
